// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the parametrised register file.
package regfile_pkg;

    localparam int unsigned RF_DATA_W_DEF   = 8;
    localparam int unsigned RF_NUM_REGS_DEF = 4;

    typedef enum logic {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_e;

endpackage

// File: rtl/regfile_rdport.sv
// Single registered read port: range check, storage mux, optional write-first bypass.
// Optional feature: REGFILE_BYPASS_EN (adds the waddr compare and wdata forwarding).
module regfile_rdport
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = RF_DATA_W_DEF,
    parameter int unsigned NUM_REGS = RF_NUM_REGS_DEF,
    parameter int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              sysclk,
    input  logic              rst,
    input  logic              en_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] regs_i [NUM_REGS],
`ifdef REGFILE_BYPASS_EN
    input  logic              byp_we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
`endif
    output logic [DATA_W-1:0] rdata_o
);

    localparam bit POW2 = (NUM_REGS == (2 ** ADDR_W));

    logic              in_range_c;
    logic [DATA_W-1:0] rdata_d;
    logic [DATA_W-1:0] rdata_q;

    // Every address decodes to a register when the depth is a power of two.
    if (POW2) begin : g_full
        assign in_range_c = 1'b1;
    end else begin : g_part
        assign in_range_c = (addr_i < ADDR_W'(NUM_REGS));
    end

    // Select captured data; hold when not enabled, zero for unmapped addresses.
    always_comb begin
        rdata_d = rdata_q;
        if (en_i) begin
            if (!in_range_c) begin
                rdata_d = '0;
            end else begin
                rdata_d = regs_i[addr_i];
`ifdef REGFILE_BYPASS_EN
                if (byp_we_i && (addr_i == waddr_i)) begin
                    rdata_d = wdata_i;
                end
`endif
            end
        end
    end

    // Output data register.
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/regfile_param.sv
// NUM_REGS x DATA_W register file: one write port, two registered read ports,
// sequential bulk-clear. Optional feature: REGFILE_BYPASS_EN (write-first reads).
module regfile_param
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = RF_DATA_W_DEF,
    parameter int unsigned NUM_REGS = RF_NUM_REGS_DEF,
    parameter int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              sysclk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr0,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              rvalid,
    input  logic              clr_req,
    output logic              busy
);

    localparam bit POW2 = (NUM_REGS == (2 ** ADDR_W));

    rf_state_e         state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              busy_q, busy_d;
    logic              rvalid_q, rvalid_d;
    logic              wr_en_c, clr_en_c, rd_en_c, waddr_ok_c;
    logic [DATA_W-1:0] regs_q [NUM_REGS];

    // Write address range check, pruned away for power-of-two depths.
    if (POW2) begin : g_wfull
        assign waddr_ok_c = 1'b1;
    end else begin : g_wpart
        assign waddr_ok_c = (waddr < ADDR_W'(NUM_REGS));
    end

    // FSM and status registers.
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            state_q  <= RF_IDLE;
            idx_q    <= '0;
            busy_q   <= 1'b0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            busy_q   <= busy_d;
            rvalid_q <= rvalid_d;
        end
    end

    // Next state: IDLE waits for clr_req, CLEAR walks idx to the last register.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            RF_IDLE: begin
                if (clr_req) begin
                    state_d = RF_CLEAR;
                    idx_d   = '0;
                end
            end
            RF_CLEAR: begin
                idx_d = idx_q + ADDR_W'(1);
                if (idx_q == ADDR_W'(NUM_REGS - 1)) begin
                    state_d = RF_IDLE;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = RF_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Datapath controls; ports are serviced only in IDLE.
    always_comb begin
        wr_en_c  = 1'b0;
        rd_en_c  = 1'b0;
        clr_en_c = 1'b0;
        busy_d   = (state_d == RF_CLEAR);
        rvalid_d = 1'b0;
        if (state_q == RF_IDLE) begin
            wr_en_c  = we && waddr_ok_c;
            rd_en_c  = re;
            rvalid_d = re;
        end else begin
            clr_en_c = 1'b1;
        end
    end

    // Storage array: IDLE writes or one clear per cycle.
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= '0;
            end
        end else if (clr_en_c) begin
            regs_q[idx_q] <= '0;
        end else if (wr_en_c) begin
            regs_q[waddr] <= wdata;
        end
    end

    regfile_rdport #(
        .DATA_W  (DATA_W),
        .NUM_REGS(NUM_REGS),
        .ADDR_W  (ADDR_W)
    ) u_rd0 (
        .sysclk  (sysclk),
        .rst     (rst),
        .en_i    (rd_en_c),
        .addr_i  (raddr0),
        .regs_i  (regs_q),
`ifdef REGFILE_BYPASS_EN
        .byp_we_i(wr_en_c),
        .waddr_i (waddr),
        .wdata_i (wdata),
`endif
        .rdata_o (rdata0)
    );

    regfile_rdport #(
        .DATA_W  (DATA_W),
        .NUM_REGS(NUM_REGS),
        .ADDR_W  (ADDR_W)
    ) u_rd1 (
        .sysclk  (sysclk),
        .rst     (rst),
        .en_i    (rd_en_c),
        .addr_i  (raddr1),
        .regs_i  (regs_q),
`ifdef REGFILE_BYPASS_EN
        .byp_we_i(wr_en_c),
        .waddr_i (waddr),
        .wdata_i (wdata),
`endif
        .rdata_o (rdata1)
    );

    assign busy   = busy_q;
    assign rvalid = rvalid_q;

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: a 4-deep and a 3-deep instance share stimulus and
// are compared each cycle against a per-instance behavioural model.
module tb_regfile_param;

    logic       sysclk = 1'b0;
    logic       rst = 1'b1;
    logic       we = 1'b0, re = 1'b0, clr_req = 1'b0;
    logic [1:0] waddr = '0, raddr0 = '0, raddr1 = '0;
    logic [7:0] wdata = '0;

    logic [7:0] rd0_a, rd1_a, rd0_b, rd1_b;
    logic       rv_a, rv_b, busy_a, busy_b;

    int checks = 0;
    int errors = 0;

    // Reference model state, index 0: depth 4, index 1: depth 3.
    logic [7:0] mem   [2][4];
    int         clr_left [2];
    logic [7:0] e_rd0 [2];
    logic [7:0] e_rd1 [2];
    logic       e_rv  [2];

    always #5 sysclk = ~sysclk;

    regfile_param #(.DATA_W(8), .NUM_REGS(4)) dut_a (
        .sysclk(sysclk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .re(re), .raddr0(raddr0), .raddr1(raddr1), .rdata0(rd0_a), .rdata1(rd1_a),
        .rvalid(rv_a), .clr_req(clr_req), .busy(busy_a)
    );

    regfile_param #(.DATA_W(8), .NUM_REGS(3)) dut_b (
        .sysclk(sysclk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .re(re), .raddr0(raddr0), .raddr1(raddr1), .rdata0(rd0_b), .rdata1(rd1_b),
        .rvalid(rv_b), .clr_req(clr_req), .busy(busy_b)
    );

    task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 4; i++) mem[d][i] = 8'h00;
            clr_left[d] = 0;
            e_rd0[d] = 8'h00;
            e_rd1[d] = 8'h00;
            e_rv[d]  = 1'b0;
        end
    endtask

    function automatic logic [7:0] model_rd(input int d, input int n, input int a);
        if (a >= n) return 8'h00;
`ifdef REGFILE_BYPASS_EN
        if (we && int'(waddr) == a) return wdata;
`endif
        return mem[d][a];
    endfunction

    // One clock edge of the abstract behaviour, using the inputs present at the edge.
    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            int n;
            n = (d == 0) ? 4 : 3;
            if (clr_left[d] > 0) begin
                mem[d][n - clr_left[d]] = 8'h00;
                clr_left[d]--;
                e_rv[d] = 1'b0;
            end else begin
                if (re) begin
                    e_rd0[d] = model_rd(d, n, int'(raddr0));
                    e_rd1[d] = model_rd(d, n, int'(raddr1));
                end
                e_rv[d] = re;
                if (we && int'(waddr) < n) mem[d][int'(waddr)] = wdata;
                if (clr_req) clr_left[d] = n;
            end
        end
    endtask

    task automatic check_all();
        chk("rdata0", 0, 32'(rd0_a), 32'(e_rd0[0]));
        chk("rdata1", 0, 32'(rd1_a), 32'(e_rd1[0]));
        chk("rvalid", 0, 32'(rv_a), 32'(e_rv[0]));
        chk("busy",   0, 32'(busy_a), 32'(clr_left[0] > 0));
        chk("rdata0", 1, 32'(rd0_b), 32'(e_rd0[1]));
        chk("rdata1", 1, 32'(rd1_b), 32'(e_rd1[1]));
        chk("rvalid", 1, 32'(rv_b), 32'(e_rv[1]));
        chk("busy",   1, 32'(busy_b), 32'(clr_left[1] > 0));
    endtask

    task automatic tick();
        @(posedge sysclk);
        model_step();
        @(negedge sysclk);
        check_all();
    endtask

    task automatic idle_inputs();
        we = 1'b0; re = 1'b0; clr_req = 1'b0;
        waddr = '0; raddr0 = '0; raddr1 = '0; wdata = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rd0"},  0, 32'(rd0_a), 0);
        chk({tag, "_rd1"},  0, 32'(rd1_a), 0);
        chk({tag, "_rv"},   0, 32'(rv_a), 0);
        chk({tag, "_busy"}, 0, 32'(busy_a), 0);
        chk({tag, "_rd0"},  1, 32'(rd0_b), 0);
        chk({tag, "_busy"}, 1, 32'(busy_b), 0);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic async_reset(input string tag);
        @(negedge sysclk);
        #2 rst = 1'b1;
        model_reset();
        #1 check_reset_outputs(tag);
        @(negedge sysclk);
        rst = 1'b0;
    endtask

    task automatic count_busy(input string tag, input int exp_cycles);
        int cnt;
        cnt = 0;
        while (busy_a && cnt < 20) begin
            cnt++;
            tick();
        end
        chk(tag, 0, 32'(cnt), 32'(exp_cycles));
    endtask

    task automatic read_pair(input logic [1:0] a0, input logic [1:0] a1);
        re = 1'b1; raddr0 = a0; raddr1 = a1;
        tick();
        re = 1'b0;
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [7:0] v);
        we = 1'b1; waddr = a; wdata = v;
        tick();
        we = 1'b0;
    endtask

    initial begin
        model_reset();
        #12;
        check_reset_outputs("por");
        @(negedge sysclk);
        rst = 1'b0;

        // Basic write then dual read.
        write_reg(2'd1, 8'hA5);
        write_reg(2'd2, 8'h3C);
        read_pair(2'd1, 2'd2);
        chk("rd_a5", 0, 32'(rd0_a), 32'h A5);
        chk("rd_3c", 0, 32'(rd1_a), 32'h 3C);
        chk("rv_hi", 0, 32'(rv_a), 1);
        tick();
        chk("rv_pulse", 0, 32'(rv_a), 0);

        // Same-address read/write collision.
        write_reg(2'd0, 8'h11);
        we = 1'b1; waddr = 2'd0; wdata = 8'h77; re = 1'b1; raddr0 = 2'd0; raddr1 = 2'd0;
        tick();
`ifdef REGFILE_BYPASS_EN
        chk("collide", 0, 32'(rd0_a), 32'h77);
`else
        chk("collide", 0, 32'(rd0_a), 32'h11);
`endif
        we = 1'b0;
        tick();
        chk("after_collide", 0, 32'(rd0_a), 32'h77);
        re = 1'b0;

        // Full clear with ignored activity while busy.
        for (int i = 0; i < 4; i++) write_reg(2'(i), 8'(8'h81 + i));
        clr_req = 1'b1;
        tick();
        clr_req = 1'b1; we = 1'b1; waddr = 2'd1; wdata = 8'hEE; re = 1'b1;
        raddr0 = 2'd3; raddr1 = 2'd2;
        tick();
        chk("busy_rv", 0, 32'(rv_a), 0);
        idle_inputs();
        count_busy("clr_len", 3);
        for (int i = 0; i < 4; i++) begin
            read_pair(2'(i), 2'(3 - i));
            chk("clr_zero", 0, 32'(rd0_a), 0);
        end

        // Reset on the second busy cycle, then a complete clear.
        for (int i = 0; i < 4; i++) write_reg(2'(i), 8'(8'h40 + i));
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        tick();
        async_reset("midclr");
        for (int i = 0; i < 4; i++) begin
            read_pair(2'(i), 2'(i));
            chk("midclr_zero", 0, 32'(rd0_a), 0);
        end
        write_reg(2'd2, 8'h99);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        count_busy("clr_len2", 4);

        // Unmapped address on the 3-deep instance.
        write_reg(2'd0, 8'h01);
        write_reg(2'd1, 8'h02);
        write_reg(2'd2, 8'h03);
        write_reg(2'd3, 8'h5A);
        read_pair(2'd3, 2'd2);
        chk("oob_rd", 1, 32'(rd0_b), 0);
        chk("oob_keep", 1, 32'(rd1_b), 32'h03);
        chk("inb_rd", 0, 32'(rd0_a), 32'h5A);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            we      = 1'($urandom_range(0, 1));
            re      = 1'($urandom_range(0, 1));
            clr_req = ($urandom_range(0, 29) == 0);
            waddr   = 2'($urandom);
            raddr0  = 2'($urandom);
            raddr1  = 2'($urandom);
            wdata   = 8'($urandom);
            tick();
            if (i == 200) begin
                idle_inputs();
                async_reset("rand_rst");
            end
        end
        idle_inputs();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
- Parametrised successor to the 2-register, 8-bit register file: NUM_REGS × DATA_W storage, one write port, two independent registered read ports.
- Read and write in the same cycle are allowed; in the previous generation read and write were mutually exclusive via a single rw select.
- Adds a synchronous bulk-clear sequencer (FSM) and optional write-to-read bypass.
- Sits between datapath control and the ALU operand muxes.

Parameters:
- DATA_W, 8: width of each register and of wdata/rdata.
- NUM_REGS, 4: number of registers; must be ≥ 2, need not be a power of two.
- ADDR_W, $clog2(NUM_REGS): address width; derived, do not override.

Ports:
- sysclk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- we  in  1  write enable.
- waddr  in  ADDR_W  write address.
- wdata  in  DATA_W  write data.
- re  in  1  read enable; captures both read ports.
- raddr0  in  ADDR_W  read port 0 address.
- raddr1  in  ADDR_W  read port 1 address.
- rdata0  out  DATA_W  read port 0 data (registered).
- rdata1  out  DATA_W  read port 1 data (registered).
- rvalid  out  1  one-cycle pulse: rdata0/1 updated this cycle.
- clr_req  in  1  request zeroing of all registers.
- busy  out  1  clear sequence in progress.

Behaviour:
- Reset (asynchronous, active-high), effective immediately on rst=1:
  - All storage registers = 0; rdata0 = rdata1 = 0; rvalid = 0; busy = 0; FSM = IDLE; clear index = 0.
  - Outputs hold these values while rst is high.
- Write, IDLE only: on posedge with we=1 and waddr < NUM_REGS, reg[waddr] <= wdata.
  - waddr ≥ NUM_REGS: write silently dropped.
- Read, IDLE only: on posedge with re=1, rdata0 <= reg[raddr0] and rdata1 <= reg[raddr1]; rvalid = 1 the following cycle.
  - Latency is 1 cycle.
  - Out-of-range read address returns 0.
  - With re=0, rdata0/rdata1 hold their last value and rvalid = 0.
  - Both ports may address the same register.
- Same-cycle read and write to the same address (no bypass): the read returns the old contents.
- FSM states: IDLE and CLEAR.
  - IDLE → CLEAR on clr_req=1. The clear index loads 0 and busy rises the next cycle.
  - CLEAR: one register per cycle, reg[idx] <= 0, idx increments. After idx = NUM_REGS-1 is written, go to IDLE; busy falls on the same edge.
  - A clear therefore takes exactly NUM_REGS cycles with busy=1.
- clr_req and we both asserted in IDLE in the same cycle: the write is performed, then the clear starts. Net result is that all registers end at 0.
- While busy=1:
  - we and re are ignored; no write occurs and rvalid stays 0.
  - clr_req is ignored and does not restart or extend the sequence.
  - rdata0/rdata1 hold their last value.
- rst asserted during CLEAR: immediate return to reset state. No partial clear remains visible, since reset zeroes everything.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined: when a read port address equals waddr, we=1, waddr is in range and the FSM is IDLE, that port captures wdata instead of reg[waddr] (write-first). Applies to each port independently.
- Undefined: read-first behaviour as described above. No extra comparators are synthesised.

Decomposition:
- Shared package regfile_pkg holds:
  - FSM state enum: RF_IDLE, RF_CLEAR.
  - Default width/depth constants: RF_DATA_W_DEF = 8, RF_NUM_REGS_DEF = 4.
- One natural sub-module, regfile_rdport: a single registered read port containing the address-range check, mux, and optional bypass compare. It is instantiated twice.
- Storage array and FSM live in the top level.

Test Plan:
- Reset values: assert rst mid-simulation (asynchronously, between edges) → rdata0 = rdata1 = 0, rvalid = 0 and busy = 0 immediately. All registers read back 0 after release.
- Write/read all registers: write 8'hA5 to reg 1 and 8'h3C to reg 2. Then re=1, raddr0=1, raddr1=2 → next cycle rdata0 = A5, rdata1 = 3C, rvalid = 1 for exactly 1 cycle.
- Same-address collision: reg 0 = 8'h11. Same cycle: we=1, waddr=0, wdata=8'h77, re=1, raddr0=0 → rdata0 = 11 without REGFILE_BYPASS_EN, 77 with it. A following read returns 77 in both builds.
- Clear sequence: fill all 4 registers with nonzero values, pulse clr_req → busy high for exactly 4 cycles. A we/re issued during busy has no effect (rvalid = 0, no write). Afterwards all registers read 0.
- Reset mid-clear: assert rst on the 2nd busy cycle → busy drops immediately, FSM = IDLE, all reads return 0. A new clr_req then runs the full 4 cycles.
- Non-power-of-two depth: with NUM_REGS = 3, write to addr 3 is dropped, reading addr 3 returns 0, and regs 0-2 are unchanged.
